// File: rtl/sap2_pkg.sv
// Shared types and helpers for the SAP-2 serial output port.
// Holds the UART FSM state encoding and pointer-width math.
package sap2_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Ceiling log2, floored at 1 so a 2-entry/2-clock
  // configuration still gets a 1-bit counter.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_port_tx_if.sv
// Controller-facing bundle of the output port: push request,
// data byte and the status flags returned to the flags logic.
interface out_port_tx_if;

  logic       load;
  logic [7:0] bus;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;

  modport master (
    output load,
    output bus,
    input  full,
    input  empty,
    input  busy,
    input  overflow
  );

  modport slave (
    input  load,
    input  bus,
    output full,
    output empty,
    output busy,
    output overflow
  );

endinterface

// File: rtl/out_fifo.sv
// DEPTH x 8 circular FIFO; full/empty decode the registered count.
// Push is refused on the pre-edge full, even with a same-cycle pop.
module out_fifo
  import sap2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case (1'b1)
        do_push & ~do_pop: cnt_q <= cnt_q + (AW+1)'(1);
        do_pop & ~do_push: cnt_q <= cnt_q - (AW+1)'(1);
        default:           cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/out_port_tx.sv
// SAP-2 serial output port: queues OUT bytes and sends them as
// 8N1 UART frames, LSB first, from a registered tx line.
module out_port_tx
  import sap2_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic         clk,
  input  logic         rst,
  out_port_tx_if.slave ctl,
  output logic         tx
);

  localparam int BW = clog2(CLKS_PER_BIT);
  localparam int IW = clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

  tx_state_t     state_q;
  tx_state_t     state_d;
  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic [IW-1:0] bit_q;
  logic [IW-1:0] bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          tx_q;
  logic          tx_d;
  logic          ovf_q;
  logic          pop;
  logic          baud_end;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  out_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ctl.load),
    .din   (ctl.bus),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (ctl.load && fifo_full) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so the line moves on the
  // same edge as the state change, with no combinational glitches.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign ctl.full     = fifo_full;
  assign ctl.empty    = fifo_empty;
  assign ctl.overflow = ovf_q;
  assign ctl.busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_out_port_tx.sv
// Directed bench for out_port_tx: exact frame timing, queueing,
// overflow, back-to-back spacing, async reset and pointer wrap.
module tb_out_port_tx;

  logic clk;
  logic rst;
  logic tx;
  int   cyc;
  int   n_pass;
  int   n_total;

  logic [7:0] rxq [$];
  int         rx_start [$];
  int         rx_bad;

  out_port_tx_if ifc ();

  out_port_tx #(
    .CLKS_PER_BIT (4),
    .DEPTH        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ifc),
    .tx  (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    ifc.load = 1'b1;
    ifc.bus  = b;
    step();
    ifc.load = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (ifc.busy === 1'b0 && tx === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic clear_rx();
    rxq.delete();
    rx_start.delete();
    rx_bad = 0;
  endtask

  // Independent receiver: samples each bit in its second cycle.
  task automatic rx_frame();
    logic [7:0] b;
    int s;
    b = '0;
    s = cyc;
    repeat (5) begin
      step();
      if (!rst) return;
    end
    for (int k = 0; k < 8; k++) begin
      b[k] = tx;
      if (k < 7) begin
        repeat (4) begin
          step();
          if (!rst) return;
        end
      end
    end
    repeat (4) begin
      step();
      if (!rst) return;
    end
    if (tx !== 1'b1) rx_bad++;
    rxq.push_back(b);
    rx_start.push_back(s);
  endtask

  initial begin
    rx_bad = 0;
    forever begin
      step();
      if (rst === 1'b1 && tx === 1'b0) rx_frame();
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    n_total++;
    if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx);
    else n_pass++;
    n_total++;
    if (ifc.full !== 1'b0) $display("FAIL reset_full got %b want 0", ifc.full);
    else n_pass++;
    n_total++;
    if (ifc.empty !== 1'b1) $display("FAIL reset_empty got %b want 1", ifc.empty);
    else n_pass++;
    n_total++;
    if (ifc.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", ifc.busy);
    else n_pass++;
    n_total++;
    if (ifc.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", ifc.overflow);
    else n_pass++;
    rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single();
    logic [7:0] v;
    int   werr;
    int   berr;
    logic exp;
    int   idx;
    bit   ok;
    v = 8'hA5;
    clear_rx();
    load_byte(v);
    n_total++;
    if (tx !== 1'b1 || ifc.empty !== 1'b0 || ifc.busy !== 1'b1)
      $display("FAIL single_edgeN got tx=%b empty=%b busy=%b want 1 0 1",
               tx, ifc.empty, ifc.busy);
    else n_pass++;
    werr = 0;
    berr = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      idx = (i - 1) / 4;
      if (idx == 0) exp = 1'b0;
      else if (idx == 9) exp = 1'b1;
      else exp = v[idx-1];
      if (tx !== exp) werr++;
      if (ifc.busy !== 1'b1) berr++;
    end
    n_total++;
    if (werr != 0) $display("FAIL single_wave got %0d bad cycles want 0", werr);
    else n_pass++;
    n_total++;
    if (berr != 0) $display("FAIL single_busy got %0d low cycles want 0", berr);
    else n_pass++;
    step();
    n_total++;
    if (ifc.busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL single_end got busy=%b tx=%b want 0 1", ifc.busy, tx);
    else n_pass++;
    wait_idle(20, ok);
    n_total++;
    if (rxq.size() != 1 || rxq[0] !== v)
      $display("FAIL single_rx got n=%0d b=%h want 1 a5", rxq.size(),
               (rxq.size() > 0) ? rxq[0] : 8'hxx);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    bit ok;
    clear_rx();
    ifc.load = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ifc.bus = 8'(i);
      step();
      if (i == 4) begin
        n_total++;
        if (ifc.full !== 1'b0) $display("FAIL fill_full4 got %b want 0", ifc.full);
        else n_pass++;
      end
    end
    n_total++;
    if (ifc.full !== 1'b1) $display("FAIL fill_full5 got %b want 1", ifc.full);
    else n_pass++;
    n_total++;
    if (ifc.overflow !== 1'b0) $display("FAIL fill_ovf5 got %b want 0", ifc.overflow);
    else n_pass++;
    ifc.bus = 8'h06;
    step();
    ifc.load = 1'b0;
    n_total++;
    if (ifc.overflow !== 1'b1) $display("FAIL fill_ovf6 got %b want 1", ifc.overflow);
    else n_pass++;
    wait_idle(400, ok);
    n_total++;
    if (!ok) $display("FAIL fill_drain got timeout want idle");
    else n_pass++;
    n_total++;
    if (rxq.size() != 5) $display("FAIL fill_count got %0d want 5", rxq.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      n_total++;
      if (rxq[i] !== 8'(i + 1))
        $display("FAIL fill_byte%0d got %h want %h", i, rxq[i], 8'(i + 1));
      else n_pass++;
    end
    n_total++;
    if (ifc.overflow !== 1'b1 || ifc.empty !== 1'b1)
      $display("FAIL fill_sticky got ovf=%b empty=%b want 1 1",
               ifc.overflow, ifc.empty);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (ifc.overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", ifc.overflow);
    else n_pass++;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_rx();
    ifc.load = 1'b1;
    ifc.bus  = 8'h00;
    step();
    ifc.bus  = 8'hFF;
    step();
    ifc.load = 1'b0;
    wait_idle(200, ok);
    n_total++;
    if (!ok || rxq.size() != 2)
      $display("FAIL b2b_count got ok=%0d n=%0d want 1 2", ok, rxq.size());
    else n_pass++;
    if (rxq.size() == 2) begin
      n_total++;
      if (rxq[0] !== 8'h00 || rxq[1] !== 8'hFF)
        $display("FAIL b2b_bytes got %h %h want 00 ff", rxq[0], rxq[1]);
      else n_pass++;
      n_total++;
      if (rx_start[1] - rx_start[0] != 41)
        $display("FAIL b2b_gap got %0d want 41", rx_start[1] - rx_start[0]);
      else n_pass++;
    end
    n_total++;
    if (rx_bad != 0) $display("FAIL b2b_stop got %0d bad stops want 0", rx_bad);
    else n_pass++;
  endtask

  task automatic test_simul();
    bit ok;
    clear_rx();
    load_byte(8'h5A);
    repeat (4) step();
    load_byte(8'hC3);
    repeat (36) step();
    n_total++;
    if (ifc.empty !== 1'b0 || tx !== 1'b1)
      $display("FAIL simul_pre got empty=%b tx=%b want 0 1", ifc.empty, tx);
    else n_pass++;
    load_byte(8'h96);
    n_total++;
    if (ifc.empty !== 1'b0 || ifc.full !== 1'b0 || tx !== 1'b0)
      $display("FAIL simul_pop got empty=%b full=%b tx=%b want 0 0 0",
               ifc.empty, ifc.full, tx);
    else n_pass++;
    wait_idle(200, ok);
    n_total++;
    if (!ok || rxq.size() != 3)
      $display("FAIL simul_count got ok=%0d n=%0d want 1 3", ok, rxq.size());
    else n_pass++;
    if (rxq.size() == 3) begin
      n_total++;
      if (rxq[0] !== 8'h5A || rxq[1] !== 8'hC3 || rxq[2] !== 8'h96)
        $display("FAIL simul_bytes got %h %h %h want 5a c3 96",
                 rxq[0], rxq[1], rxq[2]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_rx();
    load_byte(8'h3C);
    load_byte(8'h3C);
    repeat (13) step();
    rst = 1'b0;
    #1;
    n_total++;
    if (tx !== 1'b1 || ifc.busy !== 1'b0)
      $display("FAIL rstmid_line got tx=%b busy=%b want 1 0", tx, ifc.busy);
    else n_pass++;
    n_total++;
    if (ifc.empty !== 1'b1 || ifc.overflow !== 1'b0)
      $display("FAIL rstmid_fifo got empty=%b ovf=%b want 1 0",
               ifc.empty, ifc.overflow);
    else n_pass++;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    clear_rx();
    load_byte(8'h81);
    wait_idle(100, ok);
    n_total++;
    if (!ok || rxq.size() != 1 || rxq[0] !== 8'h81)
      $display("FAIL rstmid_after got ok=%0d n=%0d b=%h want 1 1 81", ok,
               rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
    else n_pass++;
    n_total++;
    if (rx_bad != 0) $display("FAIL rstmid_stop got %0d want 0", rx_bad);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    int bad;
    clear_rx();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      load_byte(8'h10 + 8'(i));
      wait_idle(80, ok);
      if (!ok) bad++;
    end
    n_total++;
    if (bad != 0 || rxq.size() != 10)
      $display("FAIL wrap_count got timeouts=%0d n=%0d want 0 10", bad, rxq.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < rxq.size(); i++) begin
      if (rxq[i] !== 8'h10 + 8'(i)) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL wrap_bytes got %0d wrong want 0", bad);
    else n_pass++;
    n_total++;
    if (ifc.empty !== 1'b1 || rx_bad != 0)
      $display("FAIL wrap_end got empty=%b badstop=%0d want 1 0",
               ifc.empty, rx_bad);
    else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b0;
    ifc.load = 1'b0;
    ifc.bus  = 8'h00;
    #1;
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_simul();
    test_reset_midframe();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
